// File: rtl/irq_controller_vec.sv
// irq_controller_vec: multi-source fixed-priority interrupt controller with ISR/exception residency tracking
module irq_controller_vec #(
  parameter int                 IRQ_NUM     = 16,
  parameter int                 SYNC_STAGES = 2,
  parameter logic [IRQ_NUM-1:0] EDGE_MASK   = '0,
  parameter int                 CAUSE_BASE  = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 stall_i,
  input  logic                                 exception_i,
  input  logic                                 mret_i,
  input  logic                                 mie_i,
  input  logic [IRQ_NUM-1:0]                   irq_mask_i,
  input  logic [IRQ_NUM-1:0]                   irq_req_i,
  output logic                                 irq_o,
  output logic [31:0]                          irq_cause_o,
  output logic [(IRQ_NUM>1 ? $clog2(IRQ_NUM) : 1)-1:0] irq_id_o,
  output logic [IRQ_NUM-1:0]                   irq_ret_o,
  output logic                                 busy_o
);
  localparam int IW = (IRQ_NUM > 1) ? $clog2(IRQ_NUM) : 1;

  typedef enum logic [1:0] {IDLE, ISR, EXC, ISR_EXC} state_t;

  state_t             state;
  logic [IRQ_NUM-1:0] s, s_prev, rise, pend_edge, pending, el, clr;
  logic [IW-1:0]      winner, cur_id, sel_id;
  logic [30:0]        cause_sum;
  logic               take, exc_take, ret;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = irq_req_i;
    end else begin : g_sync
      logic [IRQ_NUM-1:0] sq [SYNC_STAGES];
      // Shift raw requests through a chain of flops to resynchronise them to clk_i
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int i = 0; i < SYNC_STAGES; i++) sq[i] <= '0;
        end else begin
          sq[0] <= irq_req_i;
          for (int i = 1; i < SYNC_STAGES; i++) sq[i] <= sq[i-1];
        end
      end
      assign s = sq[SYNC_STAGES-1];
    end
  endgenerate

  assign rise     = s & ~s_prev & EDGE_MASK;
  assign pending  = (pend_edge & EDGE_MASK) | (s & ~EDGE_MASK);
  assign el       = pending & irq_mask_i;
  assign irq_o    = (state == IDLE) & mie_i & ~exception_i & (|el);
  assign take     = irq_o & ~stall_i;
  assign exc_take = exception_i & ~stall_i;
  assign ret      = mret_i & ~stall_i;
  assign clr      = take ? (IRQ_NUM'(1) << winner) : '0;
  assign busy_o   = (state == ISR) | (state == ISR_EXC);

  // Lowest set index of the eligible set wins
  always_comb begin
    winner = '0;
    for (int k = IRQ_NUM - 1; k >= 0; k--) if (el[k]) winner = IW'(k);
  end

  // Outside IDLE the reported source is the one in service
  always_comb begin
    sel_id      = (state == IDLE) ? winner : cur_id;
    cause_sum   = 31'(CAUSE_BASE) + 31'(sel_id);
    irq_cause_o = {1'b1, cause_sum};
    irq_id_o    = sel_id;
  end

  // Edge latches: a new rising edge wins over the clear caused by taking the same source
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s_prev    <= '0;
      pend_edge <= '0;
    end else begin
      s_prev    <= s;
      pend_edge <= ((pend_edge & ~clr) | rise) & EDGE_MASK;
    end
  end

  // Residency FSM; the acknowledge pulse is registered and lasts one cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      cur_id    <= '0;
      irq_ret_o <= '0;
    end else begin
      irq_ret_o <= '0;
      case (state)
        IDLE: begin
          if (take) begin
            state  <= ISR;
            cur_id <= winner;
          end else if (exc_take) state <= EXC;
        end
        ISR: begin
          if (exc_take) state <= ISR_EXC;
          else if (ret) begin
            state     <= IDLE;
            irq_ret_o <= IRQ_NUM'(1) << cur_id;
          end
        end
        EXC:     if (ret) state <= IDLE;
        default: if (ret) state <= ISR;
      endcase
    end
  end
endmodule
